rr_arb_ctrl: RTL
================

RR_ARB_CTRL -- requirements
Module: rr_arb_ctrl

Interface
REQ-001 Parameter: REQ_NUM, default 4, number of requester ports; SHALL be a power of two, at least 2.
REQ-002 Parameter: DATA_WIDTH, default 8, payload width per requester.
REQ-003 Localparam: ID_W = $clog2(REQ_NUM).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  REQ_NUM  per-requester beat valid.
REQ-007 in_ready  output  REQ_NUM  per-requester beat accept.
REQ-008 in_data  input  REQ_NUM*DATA_WIDTH  requester i payload in bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
REQ-009 arb_req  output  REQ_NUM  request vector driven into the fixed-priority arbiter tree.
REQ-010 arb_prio  output  REQ_NUM  thermometer priority vector into the tree; a 1 at bit i elevates requester i.
REQ-011 arb_data  output  REQ_NUM*DATA_WIDTH  held payloads into the tree, same packing as in_data.
REQ-012 arb_gnt  input  REQ_NUM  one-hot grant returned by the tree (combinational from arb_req/arb_prio).
REQ-013 arb_sel_data  input  DATA_WIDTH  payload selected by the tree.
REQ-014 out_valid  output  1  registered result valid.
REQ-015 out_ready  input  1  downstream accept.
REQ-016 out_data  output  DATA_WIDTH  registered winning payload.
REQ-017 out_id  output  ID_W  index of the winning requester.
REQ-018 err  output  1  sticky grant-protocol error flag.

Function
REQ-019 Each requester SHALL own a one-entry holding register (hold_v[i], hold_d[i]).
REQ-020 arb_req SHALL equal hold_v, and arb_data SHALL equal the hold_d concatenation; both are driven straight from registers.
REQ-021 The tree resolves ties toward the lower index, with {req,prio} compared as a 2-bit value; the block SHALL rely on this resolution.
REQ-022 load = ~out_valid | out_ready.
REQ-023 fire = load & (|hold_v) & grant_ok.
REQ-024 grant_ok = arb_gnt is exactly one-hot & (arb_gnt & ~hold_v) == 0.
REQ-025 pop[i] = fire & arb_gnt[i].
REQ-026 in_ready[i] SHALL be ~hold_v[i] | pop[i]; this is a combinational path from out_ready.
REQ-027 On in_valid[i] & in_ready[i], hold_v[i] SHALL be set and hold_d[i] SHALL capture the slice next cycle.
REQ-028 When pop[i] occurs without a new accept, hold_v[i] SHALL clear.
REQ-029 On fire, out_valid SHALL be set, out_data SHALL capture arb_sel_data, and out_id SHALL capture the binary index of arb_gnt.
REQ-030 On load & ~fire, out_valid SHALL clear.
REQ-031 While out_valid & ~out_ready, out_data and out_id SHALL hold stable.
REQ-032 Round-robin: on fire with winner g, arb_prio SHALL register so that bit i is 1 iff i > g.
REQ-033 Winner REQ_NUM-1 SHALL therefore yield arb_prio all zeros (wrap-around).
REQ-034 arb_prio SHALL be unchanged when there is no fire.
REQ-035 Latency: a beat accepted in cycle t is visible to the tree at t+1; with load true at t+1 it SHALL appear on out_valid at t+2.
REQ-036 Throughput: one output beat per cycle when out_ready is held high and requests are pending.
REQ-037 Error: if (|hold_v) & load & ~grant_ok, err SHALL set and stay set until reset.
REQ-038 In an error cycle there SHALL be no pop, no output load and no prio change; the payload stays held.
REQ-039 With hold_v all zero, arb_gnt SHALL be ignored and err SHALL NOT set.

Reset
REQ-040 While rst_n = 0, asynchronously: hold_v = 0, out_valid = 0, out_data = 0, out_id = 0, arb_prio = 0, err = 0.
REQ-041 hold_d SHALL be cleared to 0 during reset.
REQ-042 Consequently in_ready SHALL be all ones and arb_req all zeros during reset.
REQ-043 Reset mid-operation SHALL discard held and output beats with no partial update.
REQ-044 The first rising edge after deassertion SHALL be able to accept inputs.

Verification
REQ-045 Reset: rst_n = 0 with out_valid = 1 and all holds full -> out_valid = 0, in_ready = 1111, arb_prio = 0000, err = 0 immediately, before any clock edge.
REQ-046 Simultaneous: one beat on each of ports 0..3 (data 0xA0..0xA3) in the same cycle, out_ready = 1 -> out_id 0,1,2,3 on consecutive cycles starting 2 cycles later, out_data 0xA0..0xA3, final arb_prio = 0000.
REQ-047 Fairness: ports 1 and 3 continuously valid, out_ready = 1 -> out_id alternates 1,3,1,3; arb_prio alternates 1100, 0000.
REQ-048 Backpressure: out_valid = 1, out_id = 2 with out_ready = 0 for 5 cycles -> out_data/out_id stable, no pop, arb_prio unchanged, in_ready[2] = 0.
REQ-049 Fault: hold_v = 0001 while the model drives arb_gnt = 0011 -> err = 1 next cycle, out_valid unchanged, hold_v[0] remains 1.
REQ-050 Fault recovery: the err condition is then removed -> err stays 1 until rst_n pulse.

Source files
------------

// File: rtl/rr_arb_ctrl.sv
// rr_arb_ctrl: round-robin front end around an external fixed-priority arbiter tree,
// with per-requester holding registers, a registered output stage and a sticky grant error.
module rr_arb_ctrl #(
  parameter int REQ_NUM    = 4,
  parameter int DATA_WIDTH = 8,
  localparam int ID_W      = $clog2(REQ_NUM)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [REQ_NUM-1:0]              in_valid,
  output logic [REQ_NUM-1:0]              in_ready,
  input  logic [REQ_NUM*DATA_WIDTH-1:0]   in_data,
  output logic [REQ_NUM-1:0]              arb_req,
  output logic [REQ_NUM-1:0]              arb_prio,
  output logic [REQ_NUM*DATA_WIDTH-1:0]   arb_data,
  input  logic [REQ_NUM-1:0]              arb_gnt,
  input  logic [DATA_WIDTH-1:0]           arb_sel_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [ID_W-1:0]                 out_id,
  output logic                            err
);
  logic [REQ_NUM-1:0]            hold_v_q, hold_v_d, prio_q, prio_d, pop, acc;
  logic [REQ_NUM*DATA_WIDTH-1:0] hold_d_q, hold_d_d;
  logic                          out_valid_q, out_valid_d, err_q, err_d;
  logic [DATA_WIDTH-1:0]         out_data_q, out_data_d;
  logic [ID_W-1:0]               out_id_q, out_id_d, gnt_id;
  logic                          load, any_v, one_hot, grant_ok, fire;

  assign load     = ~out_valid_q | out_ready;
  assign any_v    = |hold_v_q;
  assign one_hot  = (arb_gnt != '0) && ((arb_gnt & (arb_gnt - 1'b1)) == '0);
  assign grant_ok = one_hot && ((arb_gnt & ~hold_v_q) == '0);
  assign fire     = load & any_v & grant_ok;
  assign pop      = {REQ_NUM{fire}} & arb_gnt;
  assign in_ready = ~hold_v_q | pop;
  assign acc      = in_valid & in_ready;
  assign hold_v_d = (hold_v_q & ~pop) | acc;

  always_comb begin
    gnt_id   = '0;
    hold_d_d = hold_d_q;
    prio_d   = prio_q;
    for (int i = 0; i < REQ_NUM; i++) begin
      gnt_id = arb_gnt[i] ? ID_W'(i) : gnt_id;
      hold_d_d[i*DATA_WIDTH +: DATA_WIDTH] = acc[i] ? in_data[i*DATA_WIDTH +: DATA_WIDTH]
                                                    : hold_d_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
    // the winner and everything below it lose priority next round
    for (int i = 0; i < REQ_NUM; i++)
      prio_d[i] = fire ? (i > int'(gnt_id)) : prio_q[i];
  end

  assign out_valid_d = fire | (out_valid_q & ~load);
  assign out_data_d  = fire ? arb_sel_data : out_data_q;
  assign out_id_d    = fire ? gnt_id : out_id_q;
  assign err_d       = err_q | (any_v & load & ~grant_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_v_q    <= '0;
      hold_d_q    <= '0;
      prio_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      hold_v_q    <= hold_v_d;
      hold_d_q    <= hold_d_d;
      prio_q      <= prio_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      err_q       <= err_d;
    end
  end

  assign arb_req   = hold_v_q;
  assign arb_data  = hold_d_q;
  assign arb_prio  = prio_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign err       = err_q;
endmodule
